// File: rtl/sm4_round_ctrl.sv
// SM4 round sequencer: key expansion and ROUNDS crypt rounds over an external T/T' unit; SM4_KEY_CACHE_EN skips re-expansion of a cached key.
// Latency: 2*ROUNDS cycles from accept edge to res_valid with expansion, ROUNDS without.
// Backpressure: one command in flight; the result is held in DONE until res_ready, with cmd_ready low meanwhile.
module sm4_round_ctrl #(
  parameter int ROUNDS = 32
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_decrypt,
  input  logic         cmd_key_new,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         rnd_sel,
  output logic [31:0]  rnd_word,
  input  logic [31:0]  rnd_tout,
  output logic         busy,
  output logic         keys_valid
);
  localparam int CW = $clog2(ROUNDS);
  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, KEYEXP, CRYPT, DONE} state_t;
  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } blk_t;

  state_t        state;
  blk_t          k_q;
  blk_t          x_q;
  logic [31:0]   rk [ROUNDS];
  logic [CW-1:0] cnt;
  logic          mode_dec;
  logic          need_exp;
  logic          last;
  logic [CW-1:0] rk_idx;
  logic [31:0]   ck;
  logic [31:0]   k_new;
  logic [31:0]   x_new;

`ifdef SM4_KEY_CACHE_EN
  assign need_exp = cmd_key_new || !keys_valid;
`else
  logic unused_key_new;
  assign unused_key_new = cmd_key_new;
  assign need_exp       = 1'b1;
`endif

  assign last   = (cnt == LAST_RND);
  assign rk_idx = mode_dec ? (LAST_RND - cnt) : cnt;
  assign k_new  = k_q.w0 ^ rnd_tout;
  assign x_new  = x_q.w0 ^ rnd_tout;

  // CK byte b of round j is ((4j+b)*7) mod 256; the 8-bit width supplies the modulo.
  always_comb begin
    ck = '0;
    for (int b = 0; b < 4; b++) begin
      ck[31-8*b -: 8] = (8'({cnt, 2'b00}) + 8'(b)) * 8'd7;
    end
  end

  always_comb begin
    rnd_sel  = 1'b0;
    rnd_word = '0;
    case (state)
      KEYEXP: begin
        rnd_sel  = 1'b1;
        rnd_word = k_q.w1 ^ k_q.w2 ^ k_q.w3 ^ ck;
      end
      CRYPT:   rnd_word = x_q.w1 ^ x_q.w2 ^ x_q.w3 ^ rk[rk_idx];
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (state == KEYEXP) begin
      rk[cnt] <= k_new;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      cnt        <= '0;
      mode_dec   <= 1'b0;
      k_q        <= '0;
      x_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x_q       <= cmd_data;
            mode_dec  <= cmd_decrypt;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (need_exp) begin
              k_q        <= cmd_key ^ FK;
              keys_valid <= 1'b0;
              state      <= KEYEXP;
            end else begin
              state <= CRYPT;
            end
          end
        end
        KEYEXP: begin
          k_q <= {k_q.w1, k_q.w2, k_q.w3, k_new};
          if (last) begin
            keys_valid <= 1'b1;
            cnt        <= '0;
            state      <= CRYPT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CRYPT: begin
          x_q <= {x_q.w1, x_q.w2, x_q.w3, x_new};
          if (last) begin
            // Output is the final state in reverse word order.
            res_data  <= {x_new, x_q.w3, x_q.w2, x_q.w1};
            res_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Bench for sm4_round_ctrl: SM4 T/T' reference unit, scoreboard of expected results and latencies.
module tb_sm4_round_ctrl;
  localparam int ROUNDS = 32;
  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;
`ifdef SM4_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  logic         ACLK, ARESET;
  logic         cmd_valid, cmd_ready, cmd_decrypt, cmd_key_new;
  logic [127:0] cmd_key, cmd_data, res_data;
  logic         res_valid, res_ready, rnd_sel, busy, keys_valid;
  logic [31:0]  rnd_word, rnd_tout;

  sm4_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_decrypt(cmd_decrypt), .cmd_key_new(cmd_key_new), .cmd_key(cmd_key), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .rnd_sel(rnd_sel),
    .rnd_word(rnd_word), .rnd_tout(rnd_tout), .busy(busy), .keys_valid(keys_valid));

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      r[31-8*b -: 8] = SBOX[2047 - 8*int'(a[31-8*b -: 8]) -: 8];
    end
    return r;
  endfunction

  logic [31:0] t_b;
  always_comb begin
    t_b      = tau(rnd_word);
    rnd_tout = rnd_sel ? (t_b ^ rol(t_b, 13) ^ rol(t_b, 23))
                       : (t_b ^ rol(t_b, 2) ^ rol(t_b, 10) ^ rol(t_b, 18) ^ rol(t_b, 24));
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    int           lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int   cyc = 0;
  int   acc_cyc = 0;
  int   n_res = 0;
  int   sel_total = 0;
  int   n_sent = 0;
  logic rv_q = 1'b0;
  logic hs_q = 1'b0;
  logic kv_model = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Monitor: latency on res_valid rise, data on handshake, cmd_ready the cycle after.
  always @(negedge ACLK) begin
    if (ARESET) begin
      rv_q = 1'b0;
      hs_q = 1'b0;
    end else begin
      if (hs_q) check("rdy_after_hs", 128'(cmd_ready), 128'(1));
      hs_q = 1'b0;
      if (rnd_sel) sel_total++;
      if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
      if (res_valid && !rv_q) begin
        if (sb.size() == 0) check("unexpected_res", 128'(1), 128'(0));
        else check("latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("spurious_res", 128'(1), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check("res_data", res_data, mon_e.data);
        end
        n_res++;
        hs_q = 1'b1;
      end
      rv_q = res_valid;
    end
  end

  task automatic send(input logic dec, input logic kn, input logic [127:0] key,
                      input logic [127:0] din, input logic [127:0] dexp);
    int   n;
    exp_t e;
    cmd_valid = 1'b1; cmd_decrypt = dec; cmd_key_new = kn; cmd_key = key; cmd_data = din;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!cmd_ready && n < 300);
    if (!cmd_ready) begin
      check("accept_timeout", 128'(0), 128'(1));
      cmd_valid = 1'b0;
      return;
    end
    e.data = dexp;
    e.lat  = (!CACHE || kn || !kv_model) ? 2 * ROUNDS : ROUNDS;
    sb.push_back(e);
    kv_model = 1'b1;
    n_sent++;
    @(posedge ACLK);
    #1;
    cmd_valid   = 1'b0;
    cmd_key     = {4{$urandom}};
    cmd_data    = {4{$urandom}};
    cmd_decrypt = 1'($urandom);
    cmd_key_new = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge ACLK);
      n++;
    end
    if (sb.size() != 0 || busy) check("drain_timeout", 128'(0), 128'(1));
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, s0, n0;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_decrypt = 1'b0; cmd_key_new = 1'b0;
    cmd_key = '0; cmd_data = '0; res_ready = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_res_data", res_data, 128'(0));
    check("rst_rnd_sel", 128'(rnd_sel), 128'(0));
    check("rst_rnd_word", 128'(rnd_word), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_keys_valid", 128'(keys_valid), 128'(0));
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // Known-answer encrypt with a fresh key.
    s0 = sel_total;
    send(1'b0, 1'b1, PT, PT, CT);
    drain();
    check("sel_cycles_exp", 128'(sel_total - s0), 128'(ROUNDS));
    check("rk_first", 128'(dut.rk[0]), 128'(32'hf12186f9));
    check("rk_last", 128'(dut.rk[ROUNDS-1]), 128'(32'h9124a012));
    check("keys_valid_set", 128'(keys_valid), 128'(1));

    send(1'b1, 1'b1, PT, CT, PT);
    drain();

    // Reused key: expansion skipped only when caching is built in.
    s0 = sel_total;
    send(1'b0, 1'b0, PT, PT, CT);
    drain();
    check("sel_cycles_reuse", 128'(sel_total - s0), 128'(CACHE ? 0 : ROUNDS));

    // Result held in DONE while commands are offered.
    res_ready = 1'b0;
    send(1'b0, 1'b0, PT, PT, CT);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("done_reached", 128'(res_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK);
      #1;
      cmd_valid = (i % 2 == 0);
      cmd_data  = {4{$urandom}};
      @(negedge ACLK);
      check("hold_data", res_data, CT);
      check("hold_cmd_ready", 128'(cmd_ready), 128'(0));
      check("hold_res_valid", 128'(res_valid), 128'(1));
    end
    @(posedge ACLK);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge ACLK);
    #1;
    @(negedge ACLK);
    check("release_busy", 128'(busy), 128'(0));
    check("release_res_valid", 128'(res_valid), 128'(0));
    check("release_sb_empty", 128'(sb.size()), 128'(0));
    @(posedge ACLK);
    #1;

    // Reset in round 17 of the crypt phase.
    send(1'b0, 1'b0, PT, PT, CT);
    n = 0;
    while (!(busy && !rnd_sel) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    check("crypt_reached", 128'(busy && !rnd_sel), 128'(1));
    repeat (17) @(negedge ACLK);
    #1;
    ARESET = 1'b1;
    #1;
    check("arst_cmd_ready", 128'(cmd_ready), 128'(1));
    check("arst_res_valid", 128'(res_valid), 128'(0));
    check("arst_res_data", res_data, 128'(0));
    check("arst_rnd_sel", 128'(rnd_sel), 128'(0));
    check("arst_rnd_word", 128'(rnd_word), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_keys_valid", 128'(keys_valid), 128'(0));
    sb.delete();
    kv_model = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    s0 = sel_total;
    send(1'b0, 1'b0, PT, PT, CT);
    drain();
    check("sel_cycles_after_rst", 128'(sel_total - s0), 128'(ROUNDS));
    check("keys_valid_after_rst", 128'(keys_valid), 128'(1));

    // Back-to-back commands with res_ready held high.
    n0 = n_res;
    send(1'b0, 1'b1, PT, PT, CT);
    send(1'b1, 1'b0, PT, CT, PT);
    send(1'b0, 1'b0, PT, PT, CT);
    drain();
    check("b2b_count", 128'(n_res - n0), 128'(3));
    check("final_sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
